// File: rtl/led_gpio_driver.sv
// led_gpio_driver: drives the board LEDs from the platform GPIO export.
// Each LED shows its GPIO bit gated by a global PWM dimming level. Every
// 0->1 edge of a GPIO bit also forces that LED fully on for STRETCH_MS
// millisecond ticks, so that short software pulses stay visible.
//
// Ports:
//   CLOCK_50  in   1  system clock
//   reset     in   1  synchronous, active-high reset
//   gpio_in   in   8  GPIO export word (same clock domain)
//   LEDG      out  8  registered LED drive, active-high
module led_gpio_driver #(
    parameter int unsigned TICK_DIV   = 50_000,
    parameter int unsigned PWM_DIV    = 195,
    parameter int unsigned DUTY       = 64,
    parameter int unsigned STRETCH_MS = 100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] gpio_in,
    output logic [7:0] LEDG
);

    localparam int unsigned N_LED  = 8;
    localparam int unsigned STR_W  = 16;
    localparam int unsigned PWM_W  = 8;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH_MS);
    // 9-bit so that DUTY = 256 compares as always-on
    localparam logic [PWM_W:0]    DUTY_CMP  = (PWM_W + 1)'(DUTY);

    logic [N_LED-1:0]  r_gpio_q;
    logic [N_LED-1:0]  r_gpio_prev;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [STR_W-1:0]  r_stretch [N_LED];

    logic [N_LED-1:0]  w_rise;
    logic [N_LED-1:0]  w_flash;
    logic              w_div_wrap;
    logic              w_tick;
    logic              w_pwm_on;

    // Edge detect, prescaler wraps and PWM compare
    always_comb begin
        w_rise     = r_gpio_q & ~r_gpio_prev;
        w_div_wrap = (r_div_cnt == DIV_LAST);
        w_tick     = (r_tick_cnt == TICK_LAST);
        w_pwm_on   = ({1'b0, r_pwm_cnt} < DUTY_CMP);
        for (int i = 0; i < int'(N_LED); i++) begin
            w_flash[i] = (r_stretch[i] != '0);
        end
    end

    // Input register and previous-sample register for edge detection
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_gpio_q    <= '0;
            r_gpio_prev <= '0;
        end else begin
            r_gpio_q    <= gpio_in;
            r_gpio_prev <= r_gpio_q;
        end
    end

    // PWM prescaler and 8-bit PWM phase counter
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Millisecond tick prescaler
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Per-lane flash counters: a rising edge reloads and beats a same-cycle tick
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < int'(N_LED); i++) begin
                r_stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_LED); i++) begin
                if (w_rise[i]) begin
                    r_stretch[i] <= STR_LOAD;
                end else if (w_tick && w_flash[i]) begin
                    r_stretch[i] <= r_stretch[i] - STR_W'(1);
                end
            end
        end
    end

    // LED drive: flash overrides, otherwise PWM-dimmed GPIO level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            LEDG <= '0;
        end else begin
            LEDG <= w_flash | (r_gpio_q & {N_LED{w_pwm_on}});
        end
    end

endmodule

// File: tb/tb_led_gpio_driver.sv
// Testbench for led_gpio_driver. Three instances share the inputs and differ
// only in DUTY (64, 0, 256). The reference model works on absolute edge
// indices counted from reset release: PWM phase and tick count are plain
// divisions of that index, and a lane's flash is the load value minus the
// number of ticks seen since its latest load.
module tb_led_gpio_driver;

    localparam int TICK = 10;
    localparam int PDIV = 1;
    localparam int STR  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] led64, led0, led256;

    always #5 clk = ~clk;

    led_gpio_driver #(.TICK_DIV(TICK), .PWM_DIV(PDIV), .DUTY(64), .STRETCH_MS(STR)) dut (
        .CLOCK_50(clk), .reset(reset), .gpio_in(gpio_in), .LEDG(led64));
    led_gpio_driver #(.TICK_DIV(TICK), .PWM_DIV(PDIV), .DUTY(0), .STRETCH_MS(STR)) dut_d0 (
        .CLOCK_50(clk), .reset(reset), .gpio_in(gpio_in), .LEDG(led0));
    led_gpio_driver #(.TICK_DIV(TICK), .PWM_DIV(PDIV), .DUTY(256), .STRETCH_MS(STR)) dut_d256 (
        .CLOCK_50(clk), .reset(reset), .gpio_in(gpio_in), .LEDG(led256));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    int         k = 0;          // index of the upcoming non-reset edge
    int         load_e [8];     // edge index of latest flash load, -1 if none
    logic [7:0] gq1, gq2;       // sampled GPIO one and two edges ago
    logic       rs;
    logic [7:0] gs, rise;
    logic [7:0] x64, x0, x256;

    function automatic int ticks_thru(input int x);
        return (x + 1) / TICK;
    endfunction

    function automatic int model_stretch(input int m, input int i);
        int d;
        if (load_e[i] < 0) return 0;
        d = ticks_thru(m) - ticks_thru(load_e[i]);
        return (d >= STR) ? 0 : STR - d;
    endfunction

    function automatic logic model_pwm(input int e, input int duty);
        return ((e / PDIV) % 256) < duty;
    endfunction

    // Compare process: every cycle, all three instances against the model
    always begin
        @(posedge clk);
        rs = reset;
        gs = gpio_in;
        #1;
        if (rs) begin
            k   = 0;
            gq1 = '0;
            gq2 = '0;
            for (int i = 0; i < 8; i++) load_e[i] = -1;
            x64  = '0;
            x0   = '0;
            x256 = '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                x64[i]  = (model_stretch(k - 1, i) != 0) | (gq1[i] & model_pwm(k, 64));
                x0[i]   = (model_stretch(k - 1, i) != 0) | (gq1[i] & model_pwm(k, 0));
                x256[i] = (model_stretch(k - 1, i) != 0) | (gq1[i] & model_pwm(k, 256));
            end
            rise = gq1 & ~gq2;
            for (int i = 0; i < 8; i++) if (rise[i]) load_e[i] = k;
            gq2 = gq1;
            gq1 = gs;
            k++;
        end
        check8("model_duty64", led64, x64);
        check8("model_duty0", led0, x0);
        check8("model_duty256", led256, x256);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) check_int("wait_k_timeout", k, target, target);
    endtask

    // One-cycle pulse timed so the flash load happens at edge L
    task automatic pulse_load(input logic [7:0] mask, input int l);
        wait_k(l - 1);
        gpio_in = gpio_in | mask;
        @(negedge clk);
        gpio_in = gpio_in & ~mask;
    endtask

    function automatic int next_at(input int from, input int ph);
        int l = from;
        while (l % TICK != ph) l++;
        return l;
    endfunction

    // Length of the next high run of a DUTY=0 LED bit
    task automatic run_len(input int b, output int n);
        int g = 0;
        n = 0;
        while (!led0[b] && g < 500) begin
            @(negedge clk);
            g++;
        end
        while (led0[b] && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n3, n4, n5, n2, hi, rises, l;
    logic [7:0] others;
    logic       first_s, prev_s;

    initial begin
        reset   = 1'b1;
        gpio_in = 8'hFF;

        // Reset held with all inputs high, then power-on flash
        repeat (3) @(posedge clk);
        #1 check8("reset_hold", led64, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check8("poweron_edge1_duty0", led0, 8'h00);
        @(posedge clk);
        #1 check8("poweron_edge2_duty0", led0, 8'hFF);
        check8("poweron_edge2_duty64", led64, 8'hFF);

        // PWM window on bit 0 after the flash has expired
        @(negedge clk);
        gpio_in = 8'h01;
        repeat (40) @(negedge clk);
        hi = 0; rises = 0; others = '0;
        first_s = led64[0];
        prev_s  = first_s;
        for (int c = 0; c < 256; c++) begin
            if (led64[0]) hi++;
            if (c > 0 && led64[0] && !prev_s) rises++;
            others = others | {led64[7:1], 1'b0};
            prev_s = led64[0];
            @(negedge clk);
        end
        if (first_s && !prev_s) rises++;
        check_int("pwm_high_count", hi, 64, 64);
        check_int("pwm_single_run", rises, 1, 1);
        check8("pwm_other_bits", others, 8'h00);

        gpio_in = 8'h00;
        repeat (40) @(negedge clk);

        // Single-cycle pulse on bit 3 at an arbitrary tick phase
        l = k + 3 + int'($urandom_range(0, 9));
        fork
            run_len(3, n3);
            pulse_load(8'h08, l);
        join
        check_int("flash_length", n3, 21, 30);
        repeat (40) @(negedge clk);

        // Retrigger bit 3 while its counter is at 1: no gap, full reload
        l = next_at(k + 3, 0);
        fork
            run_len(3, n4);
            begin
                pulse_load(8'h08, l);
                pulse_load(8'h08, l + 24);
            end
        join
        check_int("retrigger_run", n4, 49, 49);
        repeat (40) @(negedge clk);

        // Load on bit 5 at a tick edge while bit 2 decrements on that tick
        l = next_at(k + 10, 9);
        fork
            run_len(5, n5);
            run_len(2, n2);
            begin
                pulse_load(8'h04, l - 5);
                pulse_load(8'h20, l);
            end
        join
        check_int("load_beats_tick_bit5", n5, 30, 30);
        check_int("decrement_bit2", n2, 25, 25);
        repeat (40) @(negedge clk);

        // Reset while stretch[3] = 2
        l = next_at(k + 3, 0);
        pulse_load(8'h08, l);
        wait_k(l + 10);
        reset = 1'b1;
        @(posedge clk);
        #1 check8("midflash_reset_duty64", led64, 8'h00);
        check8("midflash_reset_duty0", led0, 8'h00);
        check8("midflash_reset_duty256", led256, 8'h00);
        @(negedge clk);
        gpio_in = 8'hFF;
        @(negedge clk);
        reset = 1'b0;

        // DUTY bounds with all inputs held high after the flash ends
        repeat (60) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check8("duty0_steady", led0, 8'h00);
            check8("duty256_steady", led256, 8'hFF);
            repeat (97) @(negedge clk);
        end

        // Randomised phase: sparse toggles, bursts and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = int'($urandom_range(0, 7));
                gpio_in[b] = ~gpio_in[b];
            end
            if ($urandom_range(0, 99) == 0) gpio_in = 8'($urandom);
        end

        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_gpio_driver.md
# led_gpio_driver

Output stage between the NIOS II platform's 8-bit GPIO export and the board LEDs (LEDG[7:0]). Consumes the GPIO word and drives each LED with a global PWM dimming level. Each LED also flashes at full brightness for a fixed time on every 0->1 transition of its GPIO bit, so short software pulses stay visible. One clock domain (CLOCK_50), fully synchronous.

## Interface

Parameters:
- TICK_DIV, 50_000: clocks per millisecond tick (1 ms at 50 MHz); minimum 1.
- PWM_DIV, 195: clocks per PWM step; 256 steps per period (~1 kHz at 50 MHz); minimum 1.
- DUTY, 64: PWM on-steps per period, range 0..256; 0 = always off, 256 = always on.
- STRETCH_MS, 100: flash length in ms ticks, range 0..65535; 0 disables the flash.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- gpio_in  in  8  GPIO export word from the platform; same clock domain.
- LEDG  out  8  registered LED drive, active-high.

## Operation

- Input register: gpio_q <= gpio_in and gpio_prev <= gpio_q on every clock.
- Rise detect: rise[i] = gpio_q[i] & ~gpio_prev[i], combinational.
- PWM prescaler: div_cnt counts 0..PWM_DIV-1 and wraps. On wrap, pwm_cnt (8-bit) increments, wrapping 255->0.
- pwm_on = (pwm_cnt < DUTY). The compare is 9-bit so that DUTY=256 is always true.
- ms tick: tick_cnt counts 0..TICK_DIV-1. tick pulses for one cycle when tick_cnt == TICK_DIV-1.
- Per-LED stretch counter stretch[i], 16-bit:
  - If rise[i], load STRETCH_MS. This restarts an active flash, and load wins over a same-cycle tick.
  - Else if tick and stretch[i] != 0, decrement by 1.
  - Else hold. The counter never wraps below 0.
- LED output: LEDG[i] <= (stretch[i] != 0) | (gpio_q[i] & pwm_on).
- All 8 lanes are independent. Multiple simultaneous rises are each handled in the same cycle.

## Timing

- Reset (synchronous, on the clock edge where reset is sampled high) clears all of the following to 0, taking effect at that edge:
  - gpio_q and gpio_prev
  - div_cnt, pwm_cnt and tick_cnt
  - all stretch counters
  - LEDG
- Reset mid-flash: LEDG goes to 0 at the first edge with reset high, and the flash is abandoned.
- After reset release, any gpio_in bit already high produces a rise, because gpio_prev = 0. This gives a power-on flash, which is intended behaviour.
- Flash latency:
  - gpio_in bit sampled high at edge N (gpio_q = 1).
  - stretch loaded at edge N+1.
  - LEDG[i] = 1 from flash at edge N+2.
- Flash length: the LED is held for STRETCH_MS ticks after the load. The duration is between (STRETCH_MS-1)*TICK_DIV+1 and STRETCH_MS*TICK_DIV cycles, depending on tick phase.
- PWM:
  - pwm_on is high for DUTY*PWM_DIV cycles out of every 256*PWM_DIV cycles.
  - High phase is at the start of the period (pwm_cnt = 0).
  - LEDG follows pwm_on with 1 cycle of latency.
- STRETCH_MS = 0: rise loads 0, no flash; LEDG is the pure PWM-gated GPIO value.
- A gpio_in pulse of a single clock still produces a full flash. A 1->0 transition never affects stretch.

## Test plan

Bench parameters: TICK_DIV=10, PWM_DIV=1, DUTY=64, STRETCH_MS=3.

1. Reset: gpio_in=8'hFF with reset held 3 cycles -> LEDG=8'h00 during reset. After release, all 8 LEDs flash simultaneously, LEDG=8'hFF 2 cycles after the first sampling edge.
2. PWM: gpio_in=8'h01 held past flash expiry -> LEDG[0] is high for exactly 64 consecutive cycles of every 256; LEDG[7:1]=0 throughout.
3. Flash: gpio_in=8'h08 for 1 cycle, then 8'h00 -> LEDG[3] rises at N+2 and stays high 21..30 cycles, then 0; other bits stay 0.
4. Retrigger: second 1-cycle pulse on bit 3 while stretch[3]=1 -> stretch reloads to 3 and LEDG[3] has no low gap.
5. Simultaneous rise and tick: rise on bit 5 in the cycle tick=1 -> stretch[5]=3 (not 2). Rise on bit 5 plus a same-cycle decrement on bit 2 -> both lanes update correctly.
6. Reset mid-flash plus DUTY bounds: assert reset while stretch[3]=2 -> LEDG=0 at the next edge, counters 0. Re-run with DUTY=0 and with DUTY=256 and gpio_in=8'hFF held -> LEDG=0 and LEDG=8'hFF respectively after the flash ends.
